// File: rtl/spi_slave.sv
// SPI slave: oversamples cs_n/sclk/mosi on clk, captures nb_rx mosi bits and shifts out nb_tx miso bits.
// Latency: first miso bit 4 clk after cs_n falls; rx_valid/rx_err 4 clk after cs_n rises.
// No backpressure: the master paces the transfer; rx_valid/rx_err/tx_load are single-cycle pulses.
module spi_slave #(
  parameter int P_RX_DATA_WIDTH = 256,
  parameter int P_TX_DATA_WIDTH = 256
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cs_n,
  input  logic                       sclk,
  input  logic                       mosi,
  output logic                       miso,
  output logic                       miso_oe,
  input  logic                       y0_sclk,
  input  logic                       y0_miso,
  input  logic [7:0]                 nb_rx,
  input  logic [7:0]                 nb_tx,
  input  logic [P_TX_DATA_WIDTH-1:0] tx_data,
  output logic                       tx_load,
  output logic [P_RX_DATA_WIDTH-1:0] rx_data,
  output logic                       rx_valid,
  output logic                       rx_err
);

  // Counters are one bit wider than nb_* so a count of 256 (full default word) fits.
  localparam int CW = 9;

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_DONE} state_t;

  state_t                     state;
  logic [1:0]                 cs_ff, sclk_ff, mosi_ff;
  logic                       sclk_d;
  logic [1:0]                 sync_fill;
  logic                       cs_s, sclk_s, mosi_s;
  logic                       lead, trail;
  logic                       armed;
  logic [CW-1:0]              nbr_lim, nbt_lim;
  logic [CW-1:0]              nbr_q, nbt_q;
  logic [CW-1:0]              rx_cnt, tx_cnt, tx_cnt_nx, tx_idx;
  logic [P_RX_DATA_WIDTH-1:0] rx_sr;
  logic [P_TX_DATA_WIDTH-1:0] tx_sr, tx_sh;
  logic                       tx_bit;

  assign cs_s   = cs_ff[1];
  assign sclk_s = sclk_ff[1];
  assign mosi_s = mosi_ff[1];

  // Edges are defined relative to the idle level so both clock polarities share one datapath.
  assign lead  = (sclk_d == y0_sclk) && (sclk_s != y0_sclk);
  assign trail = (sclk_d != y0_sclk) && (sclk_s == y0_sclk);

  // Synchronizers plus sclk history; sync_fill marks when cs_s reflects the pin again after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cs_ff     <= 2'b11;
      sclk_ff   <= {2{y0_sclk}};
      mosi_ff   <= 2'b00;
      sclk_d    <= y0_sclk;
      sync_fill <= 2'b00;
    end else begin
      cs_ff     <= {cs_ff[0], cs_n};
      sclk_ff   <= {sclk_ff[0], sclk};
      mosi_ff   <= {mosi_ff[0], mosi};
      sclk_d    <= sclk_s;
      sync_fill <= {sync_fill[0], 1'b1};
    end
  end

  // Clamp bit counts to the word widths, and pick the miso bit for the post-edge tx count.
  always_comb begin
    nbr_lim = {1'b0, nb_rx};
    if (int'(nb_rx) > P_RX_DATA_WIDTH) nbr_lim = CW'(P_RX_DATA_WIDTH);
    nbt_lim = {1'b0, nb_tx};
    if (int'(nb_tx) > P_TX_DATA_WIDTH) nbt_lim = CW'(P_TX_DATA_WIDTH);

    tx_cnt_nx = tx_cnt;
    if (trail && (tx_cnt < nbt_q)) tx_cnt_nx = tx_cnt + CW'(1);
    tx_idx = nbt_q - CW'(1) - tx_cnt_nx;
    tx_sh  = tx_sr >> tx_idx;
    tx_bit = (tx_cnt_nx < nbt_q) ? tx_sh[0] : y0_miso;
  end

  // Transaction FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      armed    <= 1'b0;
      miso     <= y0_miso;
      miso_oe  <= 1'b0;
      rx_valid <= 1'b0;
      rx_err   <= 1'b0;
      tx_load  <= 1'b0;
      rx_data  <= '0;
      rx_cnt   <= '0;
      tx_cnt   <= '0;
      nbr_q    <= '0;
      nbt_q    <= '0;
      rx_sr    <= '0;
      tx_sr    <= '0;
    end else begin
      rx_valid <= 1'b0;
      rx_err   <= 1'b0;
      tx_load  <= 1'b0;
      // A transaction may only start after cs_n has genuinely been seen high.
      if (cs_s && sync_fill[1]) armed <= 1'b1;

      case (state)
        S_IDLE: begin
          miso    <= y0_miso;
          miso_oe <= 1'b0;
          if (armed && !cs_s) begin
            tx_sr   <= tx_data;
            rx_sr   <= '0;
            rx_cnt  <= '0;
            tx_cnt  <= '0;
            nbr_q   <= nbr_lim;
            nbt_q   <= nbt_lim;
            tx_load <= 1'b1;
            miso_oe <= 1'b1;
            state   <= S_ACTIVE;
          end
        end
        S_ACTIVE: begin
          if (cs_s) begin
            miso    <= y0_miso;
            miso_oe <= 1'b0;
            state   <= S_DONE;
          end else begin
            if (lead && (rx_cnt < nbr_q)) begin
              rx_sr  <= {rx_sr[P_RX_DATA_WIDTH-2:0], mosi_s};
              rx_cnt <= rx_cnt + CW'(1);
            end
            tx_cnt <= tx_cnt_nx;
            miso   <= tx_bit;
          end
        end
        S_DONE: begin
          miso <= y0_miso;
          if ((nbr_q != '0) && (rx_cnt == nbr_q)) begin
            rx_data  <= rx_sr;
            rx_valid <= 1'b1;
          end else if (rx_cnt < nbr_q) begin
            rx_err <= 1'b1;
          end
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
